pico_cpu_core: RTL and testbench

Accumulator CPU core for picoCPU. It drives the single-port 64x8 memory/port block (6-bit ADDR, RE, WE, WDATA, 1-cycle registered RDATA) as that block's only bus master. It fetches and executes the 4-instruction 8-bit ISA (ADD/JNZ/LDA/STA). Port I/O is reached by LDA/STA to addresses 0x3e/0x3f; the memory block handles decode.

---
 rtl/pico_cpu_core.sv | 153 +++++++++++++++
 tb/tb_pico_cpu_core.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pico_cpu_core.sv
// pico_cpu_core: accumulator CPU for picoCPU, sole master of the 64x8 memory/port block.
// Executes the 8-bit ADD/JNZ/LDA/STA ISA; bus outputs are decoded from state and registers.
module pico_cpu_core (
  input  logic       CLK,
  input  logic       RES_N,
  input  logic       RUN,
  output logic [5:0] ADDR,
  output logic       RE,
  output logic       WE,
  output logic [7:0] WDATA,
  input  logic [7:0] RDATA,
  output logic [5:0] PC,
  output logic [7:0] ACC,
  output logic       HALTED,
  output logic       RETIRE
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StLoad   = 3'd3,
    StLwait  = 3'd4,
    StStore  = 3'd5
  } state_e;

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpJnz = 2'b01;
  localparam logic [1:0] OpLda = 2'b10;
  localparam logic [1:0] OpSta = 2'b11;

  state_e     state_q, state_d;
  logic [5:0] pc_q, pc_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] ir_q, ir_d;

  logic [5:0] pc_inc;
  logic [7:0] imm_sext;
  state_e     run_next;
  logic       unused_ir_op;

  // Increment wraps naturally at 6 bits (0x3f -> 0x00).
  assign pc_inc   = pc_q + 6'd1;
  assign imm_sext = {{2{RDATA[5]}}, RDATA[5:0]};
  // RUN is only consulted at instruction boundaries (IDLE and retire cycles).
  assign run_next = RUN ? StFetch : StIdle;
  // Opcode bits of IR are not needed once the LOAD/STORE path has been chosen.
  assign unused_ir_op = ^ir_q[7:6];

  // Architectural state; reset clears everything asynchronously, aborting any bus cycle.
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      state_q <= StIdle;
      pc_q    <= 6'd0;
      acc_q   <= 8'd0;
      ir_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state, register updates and bus decode for the multi-cycle sequencer.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    ir_d    = ir_q;
    RE      = 1'b0;
    WE      = 1'b0;
    ADDR    = pc_q;
    WDATA   = acc_q;
    RETIRE  = 1'b0;

    unique case (state_q)
      StIdle: begin
        state_d = run_next;
      end

      StFetch: begin
        RE      = 1'b1;
        state_d = StDecode;
      end

      StDecode: begin
        // RDATA carries the fetched instruction this cycle.
        ir_d = RDATA;
        unique case (RDATA[7:6])
          OpAdd: begin
            acc_d   = acc_q + imm_sext;
            pc_d    = pc_inc;
            RETIRE  = 1'b1;
            state_d = run_next;
          end
          OpJnz: begin
            pc_d    = (acc_q != 8'd0) ? RDATA[5:0] : pc_inc;
            RETIRE  = 1'b1;
            state_d = run_next;
          end
          OpLda: begin
            pc_d    = pc_inc;
            state_d = StLoad;
          end
          OpSta: begin
            pc_d    = pc_inc;
            state_d = StStore;
          end
          default: begin
            state_d = StIdle;
          end
        endcase
      end

      StLoad: begin
        RE      = 1'b1;
        ADDR    = ir_q[5:0];
        state_d = StLwait;
      end

      StLwait: begin
        acc_d   = RDATA;
        RETIRE  = 1'b1;
        state_d = run_next;
      end

      StStore: begin
        WE      = 1'b1;
        ADDR    = ir_q[5:0];
        RETIRE  = 1'b1;
        state_d = run_next;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Debug views of the architectural registers.
  always_comb begin
    PC     = pc_q;
    ACC    = acc_q;
    HALTED = (state_q == StIdle);
  end

  // Single-port memory: a read and a write can never share a cycle.
  a_re_we_excl : assert property (@(posedge CLK) disable iff (!RES_N) !(RE && WE));
  // Each STA produces exactly one write cycle.
  a_we_single : assert property (@(posedge CLK) disable iff (!RES_N) WE |=> !WE);

endmodule

// File: tb/tb_pico_cpu_core.sv
// Bench for pico_cpu_core: 64x8 registered-read memory, an instruction-level reference model
// that predicts every bus cycle, and directed scenarios with literal expectations.
module tb_pico_cpu_core;

  logic       CLK;
  logic       RES_N;
  logic       RUN;
  logic [5:0] ADDR;
  logic       RE;
  logic       WE;
  logic [7:0] WDATA;
  logic [7:0] rdata;
  logic [5:0] PC;
  logic [7:0] ACC;
  logic       HALTED;
  logic       RETIRE;

  pico_cpu_core dut (
    .CLK    (CLK),
    .RES_N  (RES_N),
    .RUN    (RUN),
    .ADDR   (ADDR),
    .RE     (RE),
    .WE     (WE),
    .WDATA  (WDATA),
    .RDATA  (rdata),
    .PC     (PC),
    .ACC    (ACC),
    .HALTED (HALTED),
    .RETIRE (RETIRE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory: program image is copied in on a do_load cycle; otherwise 1-cycle registered read.
  logic [7:0] mem [64];
  logic [7:0] img [64];
  logic       do_load;

  always @(posedge CLK) begin
    if (do_load) begin
      for (int i = 0; i < 64; i++) mem[i] <= img[i];
    end else begin
      if (WE) mem[ADDR] <= WDATA;
      if (RE) rdata <= mem[ADDR];
    end
  end

  int checks;
  int errors;
  int we_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Everything visible on the DUT pins in one cycle.
  typedef struct packed {
    logic       re;
    logic       we;
    logic [5:0] addr;
    logic [7:0] wdata;
    logic       retire;
    logic [5:0] pc;
    logic [7:0] acc;
    logic       halted;
  } obs_t;

  function automatic obs_t mk(input logic re, input logic we, input logic [5:0] addr,
                              input logic [7:0] wd, input logic ret, input logic [5:0] pc,
                              input logic [7:0] acc, input logic h);
    obs_t o;
    o.re = re; o.we = we; o.addr = addr; o.wdata = wd;
    o.retire = ret; o.pc = pc; o.acc = acc; o.halted = h;
    return o;
  endfunction

  // Reference model: ISA-level state plus the predicted cycle trace of the current instruction.
  logic [7:0] m_mem [64];
  logic [5:0] m_pc;
  logic [7:0] m_acc;
  logic [5:0] nxt_pc;
  logic [7:0] nxt_acc;
  bit         st_pend;
  logic [5:0] st_a;
  bit         exp_fetch;
  obs_t       exp_q[$];

  // Execute the instruction at m_pc abstractly and queue the bus cycles it must produce.
  task automatic plan();
    logic [7:0] ins;
    logic [5:0] a;
    logic [5:0] pc1;
    int         v;
    ins     = m_mem[m_pc];
    a       = ins[5:0];
    pc1     = m_pc + 6'd1;
    nxt_pc  = pc1;
    nxt_acc = m_acc;
    st_pend = 0;
    st_a    = a;
    exp_q.push_back(mk(1'b1, 1'b0, m_pc, m_acc, 1'b0, m_pc, m_acc, 1'b0));
    case (ins[7:6])
      2'b00: begin
        v       = (a >= 6'd32) ? int'(a) - 64 : int'(a);
        nxt_acc = 8'((int'(m_acc) + v + 256) % 256);
        exp_q.push_back(mk(1'b0, 1'b0, m_pc, m_acc, 1'b1, m_pc, m_acc, 1'b0));
      end
      2'b01: begin
        if (m_acc != 8'd0) nxt_pc = a;
        exp_q.push_back(mk(1'b0, 1'b0, m_pc, m_acc, 1'b1, m_pc, m_acc, 1'b0));
      end
      2'b10: begin
        nxt_acc = m_mem[a];
        exp_q.push_back(mk(1'b0, 1'b0, m_pc, m_acc, 1'b0, m_pc, m_acc, 1'b0));
        exp_q.push_back(mk(1'b1, 1'b0, a, m_acc, 1'b0, pc1, m_acc, 1'b0));
        exp_q.push_back(mk(1'b0, 1'b0, pc1, m_acc, 1'b1, pc1, m_acc, 1'b0));
      end
      default: begin
        st_pend = 1;
        exp_q.push_back(mk(1'b0, 1'b0, m_pc, m_acc, 1'b0, m_pc, m_acc, 1'b0));
        exp_q.push_back(mk(1'b0, 1'b1, a, m_acc, 1'b1, pc1, m_acc, 1'b0));
      end
    endcase
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle.
  task automatic compare_cycle();
    obs_t act;
    obs_t e;
    act = mk(RE, WE, ADDR, WDATA, RETIRE, PC, ACC, HALTED);
    if (do_load) for (int i = 0; i < 64; i++) m_mem[i] = img[i];
    if (!RES_N) begin
      m_pc = 6'd0;
      m_acc = 8'd0;
      exp_q.delete();
      exp_fetch = 0;
      chk("reset_outputs", act, mk(1'b0, 1'b0, 6'd0, 8'd0, 1'b0, 6'd0, 8'd0, 1'b1));
      return;
    end
    if (WE) we_seen++;
    if (exp_q.size() == 0 && exp_fetch) plan();
    if (exp_q.size() == 0) begin
      chk("idle_cycle", act, mk(1'b0, 1'b0, m_pc, m_acc, 1'b0, m_pc, m_acc, 1'b1));
      exp_fetch = RUN;
    end else begin
      e = exp_q.pop_front();
      chk("exec_cycle", act, e);
      if (e.retire) begin
        m_pc  = nxt_pc;
        m_acc = nxt_acc;
        if (st_pend) m_mem[st_a] = e.wdata;
        exp_fetch = RUN;
      end
    end
  endtask

  // One clock: model check at negedge, then land 1 time unit after the rising edge.
  task automatic cyc();
    @(negedge CLK);
    compare_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_img();
    for (int i = 0; i < 64; i++) img[i] = 8'h00;
  endtask

  // Hold reset, load img, then release with the given RUN level.
  task automatic start(input logic run_at_release);
    RES_N   = 1'b0;
    RUN     = 1'b0;
    do_load = 1'b1;
    cyc();
    do_load = 1'b0;
    cyc();
    RUN   = run_at_release;
    RES_N = 1'b1;
  endtask

  // Run until n instructions retire, halting at the n-th; ends in the following IDLE cycle.
  task automatic run_n(input int n, input string name);
    int cnt;
    cnt = 0;
    RUN = 1'b1;
    for (int c = 0; c < 200 && cnt < n; c++) begin
      cyc();
      if (RETIRE) begin
        cnt++;
        if (cnt == n) RUN = 1'b0;
      end
    end
    RUN = 1'b0;
    chk(name, 32'(cnt), 32'(n));
    cyc();
  endtask

  task automatic chk_mem(input string name);
    int ndiff;
    ndiff = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== m_mem[i]) ndiff++;
    chk(name, 32'(ndiff), 32'd0);
  endtask

  int w0;

  initial begin
    checks  = 0;
    errors  = 0;
    we_seen = 0;
    RES_N   = 1'b0;
    RUN     = 1'b0;
    do_load = 1'b0;
    rdata   = 8'h00;

    // Reset values and first fetch; ADD sign extension (0x3f = -1, then +1).
    clear_img();
    img[0] = 8'h3f;
    img[1] = 8'h01;
    RES_N   = 1'b0;
    RUN     = 1'b1;
    do_load = 1'b1;
    cyc();
    do_load = 1'b0;
    cyc();
    chk("rst_hold", 32'({RE, WE, ADDR, WDATA, PC, ACC, HALTED, RETIRE}),
        32'({1'b0, 1'b0, 6'h00, 8'h00, 6'h00, 8'h00, 1'b1, 1'b0}));
    RES_N = 1'b1;
    chk("rel_idle", 32'({HALTED, RE}), 32'({1'b1, 1'b0}));
    cyc();
    chk("first_fetch", 32'({RE, ADDR}), 32'({1'b1, 6'h00}));
    cyc();
    chk("add1_retire", 32'({RETIRE, ACC}), 32'({1'b1, 8'h00}));
    cyc();
    chk("add1_acc", 32'({RETIRE, ACC, RE, ADDR}), 32'({1'b0, 8'hff, 1'b1, 6'h01}));
    cyc();
    chk("add2_retire", 32'(RETIRE), 32'd1);
    RUN = 1'b0;
    cyc();
    chk("add2_state", 32'({ACC, PC, HALTED}), 32'({8'h00, 6'h02, 1'b1}));

    // JNZ taken: ACC=5 at JNZ 0x0a.
    clear_img();
    img[0] = 8'h05;
    img[1] = 8'h00;
    img[2] = 8'h4a;
    start(1'b0);
    run_n(3, "jnz_t_budget");
    chk("jnz_taken", 32'({PC, ACC}), 32'({6'h0a, 8'h05}));

    // JNZ not taken: ACC=0.
    img[0] = 8'h00;
    start(1'b0);
    run_n(3, "jnz_n_budget");
    chk("jnz_not_taken", 32'({PC, ACC}), 32'({6'h03, 8'h00}));

    // LDA 0x21 then STA 0x25.
    clear_img();
    img[0]    = 8'ha1;
    img[1]    = 8'he5;
    img[6'h21] = 8'h0a;
    start(1'b1);
    w0 = we_seen;
    cyc();
    cyc();
    cyc();
    chk("lda_load", 32'({RE, WE, ADDR}), 32'({1'b1, 1'b0, 6'h21}));
    cyc();
    chk("lda_retire", 32'(RETIRE), 32'd1);
    cyc();
    chk("lda_acc", 32'({ACC, RE, ADDR}), 32'({8'h0a, 1'b1, 6'h01}));
    cyc();
    RUN = 1'b0;
    cyc();
    chk("sta_store", 32'({WE, RE, ADDR, WDATA, RETIRE}),
        32'({1'b1, 1'b0, 6'h25, 8'h0a, 1'b1}));
    cyc();
    chk("sta_after", 32'({WE, HALTED, mem[6'h25]}), 32'({1'b0, 1'b1, 8'h0a}));
    chk("sta_we_count", 32'(we_seen - w0), 32'd1);
    chk_mem("sta_mem");

    // PC wrap: JNZ to 0x3f, ADD #0 there, next fetch at 0x00.
    clear_img();
    img[0]    = 8'h01;
    img[1]    = 8'h7f;
    img[6'h3f] = 8'h00;
    start(1'b0);
    run_n(3, "wrap_budget");
    chk("wrap_pc", 32'(PC), 32'd0);
    RUN = 1'b1;
    cyc();
    chk("wrap_fetch", 32'({RE, ADDR}), 32'({1'b1, 6'h00}));
    RUN = 1'b0;
    cyc();
    cyc();
    chk("wrap_acc", 32'({ACC, HALTED}), 32'({8'h02, 1'b1}));

    // RUN dropped during LOAD: LDA finishes, core parks, then resumes at saved PC.
    clear_img();
    img[0]    = 8'ha1;
    img[1]    = 8'h03;
    img[6'h21] = 8'h0a;
    start(1'b1);
    cyc();
    cyc();
    cyc();
    RUN = 1'b0;
    cyc();
    chk("run_lwait", 32'(RETIRE), 32'd1);
    cyc();
    chk("run_halt", 32'({HALTED, ACC, PC}), 32'({1'b1, 8'h0a, 6'h01}));
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("run_parked", 32'({RE, WE, HALTED}), 32'({1'b0, 1'b0, 1'b1}));
    end
    RUN = 1'b1;
    cyc();
    chk("run_resume", 32'({RE, ADDR}), 32'({1'b1, 6'h01}));
    cyc();
    RUN = 1'b0;
    cyc();
    chk("run_add", 32'({ACC, HALTED}), 32'({8'h0d, 1'b1}));

    // Reset asserted in the STORE cycle: WE drops at once, memory untouched.
    clear_img();
    img[0]    = 8'h05;
    img[1]    = 8'he5;
    img[6'h25] = 8'h77;
    start(1'b1);
    cyc();
    cyc();
    cyc();
    cyc();
    cyc();
    chk("rst_store_we", 32'({WE, ADDR, WDATA}), 32'({1'b1, 6'h25, 8'h05}));
    #1;
    RES_N = 1'b0;
    #1;
    chk("rst_store_clr", 32'({WE, ACC, PC, HALTED}), 32'({1'b0, 8'h00, 6'h00, 1'b1}));
    cyc();
    cyc();
    chk("rst_store_mem", 32'(mem[6'h25]), 32'h77);
    chk_mem("rst_mem");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
